// File: rtl/numbers_select_feeder.sv
// Packs a serial stream of NUM_W-bit numbers into one operand word, then sweeps a
// selector index 0..SWEEP_LAST over that word through a valid/ready handshake.
module numbers_select_feeder #(
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned NUM_W      = 4,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned SWEEP_LAST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_W-1:0]         in_nib,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CNT*NUM_W-1:0] data_in,
  output logic [IDX_W-1:0]         idx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned WORD_W = NUM_CNT * NUM_W;
  localparam int unsigned CNT_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SWEEP_LAST);

  // The sweep counter must never need to wrap inside IDX_W.
  if (SWEEP_LAST >= (1 << IDX_W)) begin : g_bad_sweep_last
    $error("SWEEP_LAST does not fit in IDX_W bits");
  end

  typedef enum logic {
    FILL  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [WORD_W-1:0] shadow;
  logic [WORD_W-1:0] shadow_next;
  logic [WORD_W-1:0] data_next;
  logic [IDX_W-1:0]  idx_next;
  logic              done_next;
  logic              in_fire;
  logic              out_fire;

  // Handshake outputs decode straight from state so reset drops them at once.
  assign in_ready  = (state == FILL) && !rst;
  assign out_valid = (state == SWEEP);
  assign busy      = (state == SWEEP);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_next  = state;
    count_next  = count;
    shadow_next = shadow;
    data_next   = data_in;
    idx_next    = idx;
    done_next   = 1'b0;

    case (state)
      FILL: begin
        if (in_fire) begin
          // NOTE: blocking assignment here is deliberate: data_next below must see
          // the shadow word with this cycle's number already merged in.
          shadow_next[int'(count)*NUM_W +: NUM_W] = in_nib;
          if (count == CNT_LAST) begin
            data_next  = shadow_next;
            idx_next   = '0;
            count_next = '0;
            state_next = SWEEP;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end

      SWEEP: begin
        if (out_fire) begin
          if (idx == IDX_LAST) begin
            state_next = FILL;
            done_next  = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end

      default: state_next = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // NOTE: the shadow word is reset along with the rest so an aborted frame can
  // never leak stale numbers into the next operand word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      data_in    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      shadow     <= shadow_next;
      data_in    <= data_next;
      idx        <= idx_next;
      frame_done <= done_next;
    end
  end

endmodule

// File: tb/tb_numbers_select_feeder.sv
// Self-checking bench for numbers_select_feeder: a table-driven first frame, directed
// corner sequences and a randomized run, all compared against a queue-based model.
module tb_numbers_select_feeder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nib;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_in;
  logic [3:0]  idx;
  logic        busy;
  logic        frame_done;

  numbers_select_feeder #(
    .NUM_CNT(4), .NUM_W(4), .IDX_W(4), .SWEEP_LAST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_in(data_in), .idx(idx), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: numbers queue up until a frame is complete, then the sweep
  // walks indices 0..4 one per accepted handshake.
  bit          m_sweep;
  int unsigned m_q[$];
  logic [15:0] m_word;
  int unsigned m_idx;
  bit          m_done;

  task automatic model_reset();
    m_sweep = 1'b0;
    m_q.delete();
    m_word  = 16'h0;
    m_idx   = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] nib, input logic r);
    m_done = 1'b0;
    if (!m_sweep) begin
      if (v) begin
        m_q.push_back(int'(nib));
        if (m_q.size() == 4) begin
          m_word  = 16'(m_q[0] + (m_q[1] << 4) + (m_q[2] << 8) + (m_q[3] << 12));
          m_q.delete();
          m_idx   = 0;
          m_sweep = 1'b1;
        end
      end
    end else if (r) begin
      if (m_idx == 4) begin
        m_sweep = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".in_ready"},   32'(in_ready),   32'(!m_sweep));
    check({tag, ".out_valid"},  32'(out_valid),  32'(m_sweep));
    check({tag, ".busy"},       32'(busy),       32'(m_sweep));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(m_done));
    check({tag, ".data_in"},    32'(data_in),    32'(m_word));
    check({tag, ".idx"},        32'(idx),        m_idx);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 later.
  task automatic drive(input logic v, input logic [3:0] nib, input logic r);
    in_valid  = v;
    in_nib    = nib;
    out_ready = r;
    #1;
  endtask

  task automatic advance(input logic v, input logic [3:0] nib, input logic r);
    model_step(v, nib, r);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag, input logic v, input logic [3:0] nib, input logic r);
    drive(v, nib, r);
    check_model(tag);
    advance(v, nib, r);
  endtask

  // Raises rst between edges and checks the asynchronous clear before any edge.
  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".rst_in_ready"},   32'(in_ready),   32'd0);
    check({tag, ".rst_out_valid"},  32'(out_valid),  32'd0);
    check({tag, ".rst_busy"},       32'(busy),       32'd0);
    check({tag, ".rst_idx"},        32'(idx),        32'd0);
    check({tag, ".rst_data_in"},    32'(data_in),    32'd0);
    check({tag, ".rst_frame_done"}, 32'(frame_done), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  nib;
    logic        r;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [3:0]  e_idx;
    logic [15:0] e_data;
    logic        e_done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int hs;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_nib    = 4'h0;
    out_ready = 1'b0;
    model_reset();

    // First frame 1,2,3,4 with out_ready high, values sampled before each edge.
    tbl[0]  = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 16'h4321, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h1, 16'h4321, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 16'h4321, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3, 16'h4321, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 16'h4321, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h4, 16'h4321, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h4, 16'h4321, 1'b0};

    repeat (2) @(posedge clk);
    #3;
    reset_pulse("init");

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].nib, tbl[i].r);
      check($sformatf("tbl%0d.in_ready", i),   32'(in_ready),   32'(tbl[i].e_in_ready));
      check($sformatf("tbl%0d.out_valid", i),  32'(out_valid),  32'(tbl[i].e_out_valid));
      check($sformatf("tbl%0d.busy", i),       32'(busy),       32'(tbl[i].e_out_valid));
      check($sformatf("tbl%0d.idx", i),        32'(idx),        32'(tbl[i].e_idx));
      check($sformatf("tbl%0d.data_in", i),    32'(data_in),    32'(tbl[i].e_data));
      check($sformatf("tbl%0d.frame_done", i), 32'(frame_done), 32'(tbl[i].e_done));
      check_model($sformatf("tbl%0d.model", i));
      advance(tbl[i].v, tbl[i].nib, tbl[i].r);
    end

    // out_ready paced 1,0,0: exactly five handshakes, word held throughout.
    for (int i = 1; i <= 4; i++) cycle("pace_fill", 1'b1, 4'(i), 1'b0);
    hs = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'h0, (i % 3) == 0);
      if (out_valid && out_ready) hs++;
      check_model($sformatf("pace%0d", i));
      advance(1'b0, 4'h0, (i % 3) == 0);
    end
    check("pace.handshakes", 32'(hs), 32'd5);

    // in_valid held during the sweep must not leak 0xF into the next frame.
    for (int i = 1; i <= 4; i++) cycle("bp_fill", 1'b1, 4'(i), 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'hF, 1'b1);
      check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
      check_model($sformatf("bp%0d", i));
      advance(1'b1, 4'hF, 1'b1);
    end
    cycle("bp_done", 1'b0, 4'h0, 1'b0);
    cycle("bp_n0", 1'b1, 4'h9, 1'b0);
    cycle("bp_n1", 1'b1, 4'h8, 1'b0);
    cycle("bp_n2", 1'b1, 4'h7, 1'b0);
    cycle("bp_n3", 1'b1, 4'h6, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    check("bp.word", 32'(data_in), 32'h6789);
    advance(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("bp_drain", 1'b0, 4'h0, 1'b1);

    // Gapped input: data_in must hold the old word until the fourth transfer.
    for (int i = 0; i < 8; i++) begin
      drive((i % 2) == 0, 4'(4'hA + i / 2), 1'b0);
      if (i < 7) check($sformatf("gap%0d.hold", i), 32'(data_in), 32'h6789);
      check_model($sformatf("gap%0d", i));
      advance((i % 2) == 0, 4'(4'hA + i / 2), 1'b0);
    end
    drive(1'b0, 4'h0, 1'b0);
    check("gap.word", 32'(data_in), 32'hDCBA);
    advance(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("gap_drain", 1'b0, 4'h0, 1'b1);

    // Reset after two numbers: the partial frame must vanish.
    cycle("ab_n0", 1'b1, 4'h3, 1'b0);
    cycle("ab_n1", 1'b1, 4'hE, 1'b0);
    reset_pulse("abort_fill");
    for (int i = 5; i <= 8; i++) cycle("ab_fresh", 1'b1, 4'(i), 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    check("ab.word", 32'(data_in), 32'h8765);
    advance(1'b0, 4'h0, 1'b0);

    // Reset at idx=2 mid-sweep: outputs clear asynchronously, no frame_done.
    cycle("as0", 1'b0, 4'h0, 1'b1);
    cycle("as1", 1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1);
    check("as.idx_before", 32'(idx), 32'd2);
    reset_pulse("abort_sweep");
    for (int i = 0; i < 3; i++) cycle("as_after", 1'b0, 4'h0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic       v;
      logic [3:0] nib;
      logic       r;
      v   = 1'($urandom_range(0, 1));
      nib = 4'($urandom_range(0, 15));
      r   = 1'($urandom_range(0, 3) != 0);
      cycle($sformatf("rnd%0d", i), v, nib, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
